tiny8_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single tiny8 memory port between the CPU (requester A) and a second master such as a DMA or debug loader (requester B). Each side uses the same read/write/resp handshake as the CPU memory interface. The arbiter serialises accesses, registers the winning request onto the memory bus and routes the response back to the owner. An optional timeout aborts hung accesses.

---
 rtl/tiny8_types_pkg.sv | 23 ++
 rtl/tiny8_mem_arbiter_timeout_counter.sv | 56 +++++
 rtl/tiny8_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_tiny8_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny8_types_pkg.sv
// -----------------------------------------------------------------------------
// tiny8_types
//   Shared types for the tiny8 memory subsystem.
//   - tiny8_word      : 8-bit data/address word used on every memory bus.
//   - tiny8_arb_state : state of the two-requester memory arbiter.
//   - tiny8_arb_owner : identifies which requester holds (or last held) the bus.
// -----------------------------------------------------------------------------
package tiny8_types;

    typedef logic [7:0] tiny8_word;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_A = 2'd1,
        ARB_BUSY_B = 2'd2
    } tiny8_arb_state;

    typedef enum logic {
        ARB_A = 1'b0,
        ARB_B = 1'b1
    } tiny8_arb_owner;

endpackage : tiny8_types

// File: rtl/tiny8_mem_arbiter_timeout_counter.sv
// -----------------------------------------------------------------------------
// tiny8_timeout_counter
//   Counts busy cycles that pass without a memory response and flags the cycle
//   in which an access has waited its full budget.
//
//   Parameters
//     TIMEOUT  cycles allowed per access; 0 disables the counter entirely.
//   Ports
//     clk      clock, rising edge
//     rst      synchronous active-high reset
//     clear    restart the count (asserted when a new access is granted)
//     inc      one more busy cycle went by without a response
//     expired  count has reached TIMEOUT-1, i.e. this is busy cycle TIMEOUT
// -----------------------------------------------------------------------------
module tiny8_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Count value seen during busy cycle TIMEOUT (the first busy cycle sees 0).
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != LAST)) begin
            // Saturates at LAST; the owner leaves BUSY in that cycle anyway.
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (count_q == LAST);

endmodule : tiny8_timeout_counter

// File: rtl/tiny8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tiny8_mem_arbiter
//   Shares the single tiny8 memory port between requester A (CPU) and
//   requester B (DMA / debug loader). The winning request is registered onto
//   the mem_* bus; the memory response is routed combinationally back to the
//   owner. Hung accesses are aborted after TIMEOUT busy cycles with x_err.
//
//   Configuration macro
//     TINY8_ARB_ROUND_ROBIN_EN  defined  : ties go to the side that did not
//                                          win last (A, B, A, B, ...).
//                               undefined: fixed priority, A wins every tie.
//   Parameters
//     TIMEOUT        busy cycles without mem_resp before abort; 0 = never
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     a_read/a_write            A request (write wins if both), held to a_resp
//     a_address/a_wdata         A address and write data
//     a_rdata/a_resp/a_err      A read data, completion pulse, timeout flag
//     b_*                       same set for requester B
//     mem_read/mem_write        registered memory request
//     mem_address/mem_wdata     registered memory address and write data
//     mem_rdata/mem_resp        memory read data and completion
// -----------------------------------------------------------------------------
module tiny8_mem_arbiter
    import tiny8_types::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,

    input  logic      a_read,
    input  logic      a_write,
    input  tiny8_word a_address,
    input  tiny8_word a_wdata,
    output tiny8_word a_rdata,
    output logic      a_resp,
    output logic      a_err,

    input  logic      b_read,
    input  logic      b_write,
    input  tiny8_word b_address,
    input  tiny8_word b_wdata,
    output tiny8_word b_rdata,
    output logic      b_resp,
    output logic      b_err,

    output logic      mem_read,
    output logic      mem_write,
    output tiny8_word mem_address,
    output tiny8_word mem_wdata,
    input  tiny8_word mem_rdata,
    input  logic      mem_resp
);

    tiny8_arb_state state_q,       state_d;
    tiny8_arb_owner last_grant_q,  last_grant_d;
    logic           mem_read_q,    mem_read_d;
    logic           mem_write_q,   mem_write_d;
    tiny8_word      mem_address_q, mem_address_d;
    tiny8_word      mem_wdata_q,   mem_wdata_d;

    logic req_a, req_b;
    logic grant_a, grant_b;
    logic busy;
    logic expired;
    logic abort;
    logic done;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;
    assign busy  = (state_q != ARB_IDLE);

    tiny8_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state_q == ARB_IDLE) && (grant_a || grant_b)),
        .inc     (busy && !mem_resp),
        .expired (expired)
    );

    // A real response always beats the timeout in the same cycle.
    assign abort = busy && !mem_resp && expired;
    assign done  = busy && (mem_resp || abort);

    // Grant decision, only consumed while IDLE.
    always_comb begin
        grant_a = req_a;
        grant_b = req_b;
        if (req_a && req_b) begin
`ifdef TINY8_ARB_ROUND_ROBIN_EN
            grant_a = (last_grant_q == ARB_B);
`else
            grant_a = 1'b1;
`endif
            grant_b = !grant_a;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant_a) begin
                    state_d       = ARB_BUSY_A;
                    last_grant_d  = ARB_A;
                    mem_write_d   = a_write;
                    mem_read_d    = a_read && !a_write;
                    mem_address_d = a_address;
                    mem_wdata_d   = a_wdata;
                end else if (grant_b) begin
                    state_d       = ARB_BUSY_B;
                    last_grant_d  = ARB_B;
                    mem_write_d   = b_write;
                    mem_read_d    = b_read && !b_write;
                    mem_address_d = b_address;
                    mem_wdata_d   = b_wdata;
                end
            end
            ARB_BUSY_A, ARB_BUSY_B: begin
                // Address and data are left as-is; only the strobes drop.
                if (done) begin
                    state_d     = ARB_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            last_grant_q  <= ARB_B;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Response routing: only the current owner ever sees non-zero values.
    always_comb begin
        a_resp  = 1'b0;
        a_err   = 1'b0;
        a_rdata = '0;
        b_resp  = 1'b0;
        b_err   = 1'b0;
        b_rdata = '0;
        if (state_q == ARB_BUSY_A) begin
            a_resp  = done;
            a_err   = abort;
            a_rdata = mem_rdata;
        end else if (state_q == ARB_BUSY_B) begin
            b_resp  = done;
            b_err   = abort;
            b_rdata = mem_rdata;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule : tiny8_mem_arbiter

// File: tb/tb_tiny8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tiny8_mem_arbiter
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A transaction-level model (owner, age of the access, latched
//   request) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_tiny8_mem_arbiter;
    import tiny8_types::*;

    localparam int unsigned TO = 4;

    logic      clk = 1'b0;
    logic      rst;
    logic      a_read, a_write, b_read, b_write;
    tiny8_word a_address, a_wdata, b_address, b_wdata;
    tiny8_word a_rdata, b_rdata;
    logic      a_resp, a_err, b_resp, b_err;
    logic      mem_read, mem_write;
    tiny8_word mem_address, mem_wdata, mem_rdata;
    logic      mem_resp;

    always #5 clk = ~clk;

    tiny8_mem_arbiter #(
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_read      (a_read),
        .a_write     (a_write),
        .a_address   (a_address),
        .a_wdata     (a_wdata),
        .a_rdata     (a_rdata),
        .a_resp      (a_resp),
        .a_err       (a_err),
        .b_read      (b_read),
        .b_write     (b_write),
        .b_address   (b_address),
        .b_wdata     (b_wdata),
        .b_rdata     (b_rdata),
        .b_resp      (b_resp),
        .b_err       (b_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_owner: 0 = nobody, 1 = A, 2 = B. m_age: busy cycle number, first is 1.
    bit        model_on = 1'b0;
    int        m_owner, m_last, m_age, win;
    bit        m_write;
    tiny8_word m_addr, m_wdata;
    bit        x_to;

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            m_owner  = 0;
            m_last   = 2;
            m_age    = 0;
            m_write  = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
        end else if (model_on) begin
            if (m_owner != 0) begin
                if (mem_resp || (TO != 0 && m_age == int'(TO))) m_owner = 0;
                else m_age++;
            end else begin
                win = 0;
                if ((a_read || a_write) && (b_read || b_write)) begin
`ifdef TINY8_ARB_ROUND_ROBIN_EN
                    win = (m_last == 1) ? 2 : 1;
`else
                    win = 1;
`endif
                end else if (a_read || a_write) win = 1;
                else if (b_read || b_write) win = 2;
                if (win == 1) begin
                    m_write = a_write; m_addr = a_address; m_wdata = a_wdata;
                end else if (win == 2) begin
                    m_write = b_write; m_addr = b_address; m_wdata = b_wdata;
                end
                if (win != 0) begin
                    m_owner = win;
                    m_last  = win;
                    m_age   = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            x_to = (m_owner != 0) && (TO != 0) && (m_age == int'(TO)) && !mem_resp;
            check("mem_read",    mem_read,    m_owner != 0 && !m_write);
            check("mem_write",   mem_write,   m_owner != 0 && m_write);
            check("mem_address", mem_address, m_addr);
            check("mem_wdata",   mem_wdata,   m_wdata);
            check("a_resp",  a_resp,  m_owner == 1 && (mem_resp || x_to));
            check("a_err",   a_err,   m_owner == 1 && x_to);
            check("a_rdata", a_rdata, (m_owner == 1) ? mem_rdata : 8'h00);
            check("b_resp",  b_resp,  m_owner == 2 && (mem_resp || x_to));
            check("b_err",   b_err,   m_owner == 2 && x_to);
            check("b_rdata", b_rdata, (m_owner == 2) ? mem_rdata : 8'h00);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_read = 1'b0; a_write = 1'b0; a_address = '0; a_wdata = '0;
        b_read = 1'b0; b_write = 1'b0; b_address = '0; b_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
    endtask

    tiny8_word   tie_exp [3];
    bit          a_hold, b_hold, a_done, b_done;
    int unsigned op;

    initial begin
        rst = 1'b1;
        idle_inputs();
`ifdef TINY8_ARB_ROUND_ROBIN_EN
        tie_exp[0] = 8'h20; tie_exp[1] = 8'h21; tie_exp[2] = 8'h20;
`else
        tie_exp[0] = 8'h20; tie_exp[1] = 8'h20; tie_exp[2] = 8'h20;
`endif
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_read",  mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr",  mem_address, 0);
        check("rst_a_resp",    a_resp, 0);
        check("rst_b_resp",    b_resp, 0);

        // Tie, both held continuously, memory always answering.
        step();
        a_write = 1'b1; a_address = 8'h20; a_wdata = 8'h01;
        b_write = 1'b1; b_address = 8'h21; b_wdata = 8'h02;
        mem_resp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("tie_idle_write", mem_write, 0);
            step();
            @(negedge clk);
            check("tie_addr",   mem_address, tie_exp[k]);
            check("tie_a_resp", a_resp, tie_exp[k] == 8'h20);
            check("tie_b_resp", b_resp, tie_exp[k] == 8'h21);
            step();
        end
        idle_inputs();

        // Single read.
        step();
        a_read = 1'b1; a_address = 8'h10;
        @(negedge clk);
        check("rd_idle", mem_read, 0);
        step();
        @(negedge clk);
        check("rd_mem_read", mem_read, 1);
        check("rd_mem_addr", mem_address, 8'h10);
        check("rd_no_resp",  a_resp, 0);
        step();
        mem_resp = 1'b1; mem_rdata = 8'h5A;
        @(negedge clk);
        check("rd_a_resp",  a_resp, 1);
        check("rd_a_rdata", a_rdata, 8'h5A);
        check("rd_b_resp",  b_resp, 0);
        step();
        idle_inputs();
        @(negedge clk);
        check("rd_resp_gone", a_resp, 0);
        check("rd_strobe_gone", mem_read, 0);

        // Read and write together: write wins.
        step();
        a_read = 1'b1; a_write = 1'b1; a_address = 8'h44; a_wdata = 8'h77;
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        check("rw_write", mem_write, 1);
        check("rw_read",  mem_read, 0);
        check("rw_wdata", mem_wdata, 8'h77);
        check("rw_resp",  a_resp, 1);
        step();
        idle_inputs();

        // B pending while A busy.
        step();
        a_read = 1'b1; a_address = 8'h12;
        step();
        b_write = 1'b1; b_address = 8'h30; b_wdata = 8'h9C;
        @(negedge clk);
        check("pend_b_quiet", b_resp, 0);
        step();
        mem_resp = 1'b1; mem_rdata = 8'h11;
        @(negedge clk);
        check("pend_a_resp", a_resp, 1);
        check("pend_b_resp", b_resp, 0);
        check("pend_b_rdata", b_rdata, 0);
        step();
        a_read = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        check("pend_idle", mem_write, 0);
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        check("pend_b_addr",  mem_address, 8'h30);
        check("pend_b_write", mem_write, 1);
        check("pend_b_done",  b_resp, 1);
        check("pend_a_quiet", a_resp, 0);
        step();
        idle_inputs();

        // Timeout: memory never answers.
        step();
        a_read = 1'b1; a_address = 8'h40;
        for (int i = 1; i <= int'(TO); i++) begin
            step();
            @(negedge clk);
            check("to_resp",  a_resp, i == int'(TO));
            check("to_err",   a_err,  i == int'(TO));
            check("to_strobe", mem_read, 1);
        end
        step();
        a_read = 1'b0; mem_resp = 1'b1;
        @(negedge clk);
        check("to_stray_a", a_resp, 0);
        check("to_stray_b", b_resp, 0);
        check("to_idle",    mem_read, 0);
        step();
        idle_inputs();

        // Reset in the middle of a B access.
        step();
        b_read = 1'b1; b_address = 8'h55;
        step();
        rst = 1'b1; mem_rdata = 8'hEE;
        @(negedge clk);
        check("rm_busy_rdata", b_rdata, 8'hEE);
        step();
        rst = 1'b0; b_read = 1'b0;
        @(negedge clk);
        check("rm_mem_read",  mem_read, 0);
        check("rm_mem_write", mem_write, 0);
        check("rm_mem_addr",  mem_address, 0);
        check("rm_mem_wdata", mem_wdata, 0);
        check("rm_resp", {a_resp, a_err, b_resp, b_err}, 0);
        check("rm_rdata", {a_rdata, b_rdata}, 0);
        step();
        a_read = 1'b1; a_address = 8'h66;
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        check("rm_regrant_addr", mem_address, 8'h66);
        check("rm_regrant_resp", a_resp, 1);
        step();
        idle_inputs();

        // Randomized traffic.
        a_hold = 1'b0; b_hold = 1'b0; a_done = 1'b0; b_done = 1'b0;
        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (a_hold && (a_done || rst || $urandom_range(0, 15) == 0)) begin
                a_hold = 1'b0; a_read = 1'b0; a_write = 1'b0;
            end else if (!a_hold && $urandom_range(0, 2) == 0) begin
                a_hold = 1'b1;
                op = $urandom_range(0, 2);
                a_read = (op != 1); a_write = (op != 0);
                a_address = 8'($urandom); a_wdata = 8'($urandom);
            end
            if (b_hold && (b_done || rst || $urandom_range(0, 15) == 0)) begin
                b_hold = 1'b0; b_read = 1'b0; b_write = 1'b0;
            end else if (!b_hold && $urandom_range(0, 2) == 0) begin
                b_hold = 1'b1;
                op = $urandom_range(0, 2);
                b_read = (op != 1); b_write = (op != 0);
                b_address = 8'($urandom); b_wdata = 8'($urandom);
            end
            mem_resp  = ($urandom_range(0, 2) == 0);
            mem_rdata = 8'($urandom);
            @(negedge clk);
            a_done = a_resp;
            b_done = b_resp;
        end

        step();
        rst = 1'b0;
        idle_inputs();
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_tiny8_mem_arbiter
